// File: rtl/cbctrl_pkg.sv
// Shared types and constants for the codebook lookup sequencer.
package cbctrl_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2,
    FLUSH  = 2'd3
  } cbctrl_state_t;

  localparam int SYM_W = 4;
  localparam logic [SYM_W-1:0] SYM_ESC = 4'hF;
  localparam int AP_CNT_MAX_DEFAULT = 12;

endpackage

// File: rtl/codebook_ctrl_outbuf.sv
// Codeword / flush-residue holding register; contents stay put while valid and not ready.
module codebook_ctrl_outbuf
  import cbctrl_pkg::*;
#(
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_flush,
  input  logic [5:0]        load_length,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [5:0]        length,
  output logic [DATA_W-1:0] data,
  output logic              flush
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      length <= '0;
      data   <= '0;
      flush  <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      length <= load_length;
      data   <= load_data;
      flush  <= load_flush;
    end else if (valid && ready) begin
      valid  <= 1'b0;
      length <= '0;
      data   <= '0;
      flush  <= 1'b0;
    end
  end

endmodule

// File: rtl/codebook_seq_ctrl.sv
// Codebook lookup sequencer: builds the symbol prefix, drives the external codebook, emits codewords.
// Optional CBCTRL_ERR_CNT_EN adds a saturating 16-bit overflow event counter (ovf_cnt_o).
//
// state  | meaning
// ACCUM  | waiting for a symbol or a flush request
// LOOKUP | codebook inputs settled on the new prefix; sample match
// EMIT   | matched codeword held on cw_*, waiting for cw_ready_i
// FLUSH  | partial prefix reported as residue, waiting for cw_ready_i
module codebook_seq_ctrl
  import cbctrl_pkg::*;
#(
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int ENCODE_DATALENGTH   = 21,
  parameter int AP_CNT_MAX          = AP_CNT_MAX_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           sym_valid_i,
  output logic                           sym_ready_o,
  input  logic [SYM_W-1:0]               sym_data_i,
  input  logic                           flush_i,
  output logic                           flush_done_o,
  output logic [5:0]                     cb_ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] cb_ap_data_o,
  input  logic                           cb_match_i,
  input  logic [5:0]                     cb_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   cb_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [5:0]                     cw_length_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic                           cw_flush_o,
`ifdef CBCTRL_ERR_CNT_EN
  output logic [15:0]                    ovf_cnt_o,
`endif
  output logic                           ovf_err_o
);

  localparam logic [5:0] AP_CNT_LIM = 6'(AP_CNT_MAX);

  cbctrl_state_t state, state_nxt;
  logic [5:0] ap_cnt;
  logic [CODEBOOK_LENGTH_MAX-1:0] ap_data;
  logic accept, load_cw, load_flush, ovf_evt, prefix_clr, flush_done_set;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ACCUM;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: begin
        if (flush_i) begin
          if (ap_cnt != 6'd0) state_nxt = FLUSH;
        end else if (sym_valid_i) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP:  state_nxt = cb_match_i ? EMIT : ACCUM;
      EMIT:    if (cw_ready_i) state_nxt = ACCUM;
      FLUSH:   if (cw_ready_i) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    sym_ready_o = (state == ACCUM) && !flush_i;
    accept      = sym_ready_o && sym_valid_i;
    load_cw     = (state == LOOKUP) && cb_match_i;
    load_flush  = (state == ACCUM) && flush_i && (ap_cnt != 6'd0);
    ovf_evt     = (state == LOOKUP) && !cb_match_i && (ap_cnt == AP_CNT_LIM);
    prefix_clr  = ovf_evt || (((state == EMIT) || (state == FLUSH)) && cw_ready_i);
    // Gate on the registered pulse so a flush level still held for one more cycle does not re-pulse.
    flush_done_set = ((state == ACCUM) && flush_i && (ap_cnt == 6'd0) && !flush_done_o)
                  || ((state == FLUSH) && cw_ready_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ap_cnt       <= '0;
      ap_data      <= '0;
      ovf_err_o    <= 1'b0;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= flush_done_set;
      if (ovf_evt) ovf_err_o <= 1'b1;
      if (prefix_clr) begin
        ap_cnt  <= '0;
        ap_data <= '0;
      end else if (accept) begin
        ap_cnt  <= ap_cnt + 6'd1;
        ap_data <= {ap_data[CODEBOOK_LENGTH_MAX-SYM_W-1:0], sym_data_i};
      end
    end
  end

`ifdef CBCTRL_ERR_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                              ovf_cnt_o <= '0;
    else if (ovf_evt && ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 16'd1;
  end
`endif

  assign cb_ap_cnt_o  = ap_cnt;
  assign cb_ap_data_o = ap_data;

  codebook_ctrl_outbuf #(.DATA_W(ENCODE_DATALENGTH)) u_outbuf (
    .clk         (clk_i),
    .rst_n       (rst_n_i),
    .load        (load_cw || load_flush),
    .load_flush  (load_flush),
    .load_length (load_flush ? ap_cnt : cb_length_i),
    .load_data   (load_flush ? '0 : cb_data_i),
    .ready       (cw_ready_i),
    .valid       (cw_valid_o),
    .length      (cw_length_o),
    .data        (cw_data_o),
    .flush       (cw_flush_o)
  );

endmodule

// File: tb/tb_codebook_seq_ctrl.sv
// Bench for codebook_seq_ctrl: directed vector table, corner sequences, randomized run vs. a prefix model.
module tb_codebook_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        sym_valid_i, sym_ready_o;
  logic [3:0]  sym_data_i;
  logic        flush_i, flush_done_o;
  logic [5:0]  cb_ap_cnt_o;
  logic [63:0] cb_ap_data_o;
  logic        cb_match_i;
  logic [5:0]  cb_length_i;
  logic [20:0] cb_data_i;
  logic        cw_valid_o, cw_ready_i, cw_flush_o, ovf_err_o;
  logic [5:0]  cw_length_o;
  logic [20:0] cw_data_o;
`ifdef CBCTRL_ERR_CNT_EN
  logic [15:0] ovf_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cb_mode = 0;

  codebook_seq_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o), .sym_data_i(sym_data_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .cb_ap_cnt_o(cb_ap_cnt_o), .cb_ap_data_o(cb_ap_data_o),
    .cb_match_i(cb_match_i), .cb_length_i(cb_length_i), .cb_data_i(cb_data_i),
    .cw_valid_o(cw_valid_o), .cw_ready_i(cw_ready_i), .cw_length_o(cw_length_o),
    .cw_data_o(cw_data_o), .cw_flush_o(cw_flush_o),
`ifdef CBCTRL_ERR_CNT_EN
    .ovf_cnt_o(ovf_cnt_o),
`endif
    .ovf_err_o(ovf_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the external combinational codebook.
  always_comb begin
    cb_match_i  = 1'b0;
    cb_length_i = '0;
    cb_data_i   = '0;
    case (cb_mode)
      0: if (cb_ap_cnt_o == 6'd1 && cb_ap_data_o == 64'hF) begin
           cb_match_i = 1'b1; cb_length_i = 6'd10; cb_data_i = 21'h3E8;
         end
      1: if (cb_ap_cnt_o == 6'd3 && cb_ap_data_o == 64'h02F) begin
           cb_match_i = 1'b1; cb_length_i = 6'd15; cb_data_i = 21'h7FF0;
         end
      3: if (cb_ap_cnt_o != 6'd0 && cb_ap_data_o[3:0] == 4'hF) begin
           cb_match_i = 1'b1; cb_length_i = 6'(cb_ap_cnt_o * 4); cb_data_i = cb_ap_data_o[20:0];
         end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; sym_valid_i = 1'b0; sym_data_i = '0; flush_i = 1'b0; cw_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the symbol.
  task automatic send_sym(input logic [3:0] s);
    int n = 0;
    sym_valid_i = 1'b1; sym_data_i = s;
    @(negedge clk_i);
    while (!sym_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) check("sym_accept_timeout", 64'(sym_ready_o), 64'd1);
    @(posedge clk_i); #1;
    sym_valid_i = 1'b0;
  endtask

  task automatic handshake();
    cw_ready_i = 1'b1;
    @(posedge clk_i); #1;
    cw_ready_i = 1'b0;
  endtask

  typedef struct {
    int          mode;
    int          nsym;
    logic [63:0] ap;
    logic [5:0]  len;
    logic [20:0] data;
  } vec_t;

  typedef struct {
    logic [5:0]  len;
    logic [20:0] data;
    logic        flush;
    logic [63:0] ap;
  } exp_t;

  vec_t vecs[5];
  exp_t expq[$];
  logic [3:0] mq[$];
  logic ovf_m;
  int   ovf_n;

  function automatic logic [63:0] pack_q();
    logic [63:0] p = 0;
    foreach (mq[i]) p = p * 16 + 64'(mq[i]);
    return p;
  endfunction

  task automatic model_accept(input logic [3:0] s);
    exp_t e;
    mq.push_back(s);
    if (s == 4'hF) begin
      e.len = 6'(4 * mq.size()); e.data = pack_q() & 64'h1FFFFF; e.flush = 1'b0; e.ap = '0;
      expq.push_back(e);
      mq.delete();
    end else if (mq.size() == 12) begin
      ovf_m = 1'b1; ovf_n++;
      mq.delete();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s;
    exp_t e;
    logic prev_hold, flush_act, new_flush, saw_done;
    logic [5:0] p_len; logic [20:0] p_data; logic p_flush;
    int flush_age;

    vecs[0] = '{0, 1, 64'hF,     6'd10, 21'h3E8};
    vecs[1] = '{1, 3, 64'h02F,   6'd15, 21'h7FF0};
    vecs[2] = '{3, 3, 64'h12F,   6'd12, 21'h12F};
    vecs[3] = '{3, 1, 64'hF,     6'd4,  21'hF};
    vecs[4] = '{3, 5, 64'h7777F, 6'd20, 21'h7777F};

    // Reset values
    rst_n_i = 1'b0; sym_valid_i = 1'b0; sym_data_i = '0; flush_i = 1'b0; cw_ready_i = 1'b0;
    #12;
    check("rst_sym_ready", 64'(sym_ready_o), 64'd1);
    check("rst_cw_valid", 64'(cw_valid_o), 64'd0);
    check("rst_cw_length", 64'(cw_length_o), 64'd0);
    check("rst_cw_data", 64'(cw_data_o), 64'd0);
    check("rst_cw_flush", 64'(cw_flush_o), 64'd0);
    check("rst_flush_done", 64'(flush_done_o), 64'd0);
    check("rst_ovf", 64'(ovf_err_o), 64'd0);
    check("rst_ap_cnt", 64'(cb_ap_cnt_o), 64'd0);
    check("rst_ap_data", cb_ap_data_o, 64'd0);
    do_reset();

    // Directed vector table
    foreach (vecs[v]) begin
      cb_mode = vecs[v].mode;
      for (int i = vecs[v].nsym - 1; i >= 0; i--) begin
        send_sym(vecs[v].ap[4*i +: 4]);
        if (i != 0) begin
          @(negedge clk_i) check("vec_no_early_a", 64'(cw_valid_o), 64'd0);
          @(negedge clk_i) check("vec_no_early_b", 64'(cw_valid_o), 64'd0);
          @(posedge clk_i); #1;
        end
      end
      @(negedge clk_i);
      check("vec_latency_n1", 64'(cw_valid_o), 64'd0);
      check("vec_lookup_ap", cb_ap_data_o, vecs[v].ap);
      check("vec_lookup_cnt", 64'(cb_ap_cnt_o), 64'(vecs[v].nsym));
      @(negedge clk_i);
      check("vec_latency_n2", 64'(cw_valid_o), 64'd1);
      check("vec_length", 64'(cw_length_o), 64'(vecs[v].len));
      check("vec_data", 64'(cw_data_o), 64'(vecs[v].data));
      check("vec_flush", 64'(cw_flush_o), 64'd0);
      handshake();
      @(negedge clk_i);
      check("vec_clr_cnt", 64'(cb_ap_cnt_o), 64'd0);
      check("vec_clr_data", cb_ap_data_o, 64'd0);
      check("vec_clr_valid", 64'(cw_valid_o), 64'd0);
      @(posedge clk_i); #1;
    end

    // Backpressure: ready low for 5 cycles, a waiting symbol must survive
    cb_mode = 0;
    send_sym(4'hF);
    @(negedge clk_i); @(negedge clk_i);
    sym_valid_i = 1'b1; sym_data_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 64'(cw_valid_o), 64'd1);
      check("hold_length", 64'(cw_length_o), 64'd10);
      check("hold_data", 64'(cw_data_o), 64'h3E8);
      check("hold_sym_ready", 64'(sym_ready_o), 64'd0);
      @(negedge clk_i);
    end
    handshake();
    send_sym(4'hF);
    @(negedge clk_i); @(negedge clk_i);
    check("hold_second_valid", 64'(cw_valid_o), 64'd1);
    check("hold_second_len", 64'(cw_length_o), 64'd10);
    handshake();

    // Overflow after 12 unmatched symbols
    do_reset();
    cb_mode = 2;
    for (int i = 0; i < 12; i++) begin
      send_sym(4'h0);
      check("ovf_cnt_grow", 64'(cb_ap_cnt_o), 64'(i + 1));
      if (i < 11) begin
        @(negedge clk_i) check("ovf_early", 64'(ovf_err_o), 64'd0);
        @(posedge clk_i); #1;
      end
    end
    @(negedge clk_i) check("ovf_in_lookup", 64'(ovf_err_o), 64'd0);
    @(negedge clk_i);
    check("ovf_set", 64'(ovf_err_o), 64'd1);
    check("ovf_clr_cnt", 64'(cb_ap_cnt_o), 64'd0);
    check("ovf_clr_data", cb_ap_data_o, 64'd0);
`ifdef CBCTRL_ERR_CNT_EN
    check("ovf_counter", 64'(ovf_cnt_o), 64'd1);
`endif
    repeat (3) @(negedge clk_i);
    check("ovf_sticky", 64'(ovf_err_o), 64'd1);
    @(posedge clk_i); #1;

    // Flush with a simultaneous symbol
    do_reset();
    cb_mode = 3;
    send_sym(4'h1);
    send_sym(4'h3);
    @(negedge clk_i); @(posedge clk_i); #1;
    sym_valid_i = 1'b1; sym_data_i = 4'h5; flush_i = 1'b1;
    @(negedge clk_i) check("flush_blocks_sym", 64'(sym_ready_o), 64'd0);
    @(negedge clk_i);
    check("flush_valid", 64'(cw_valid_o), 64'd1);
    check("flush_flag", 64'(cw_flush_o), 64'd1);
    check("flush_length", 64'(cw_length_o), 64'd2);
    check("flush_data", 64'(cw_data_o), 64'd0);
    check("flush_ap", cb_ap_data_o, 64'h13);
    check("flush_done_early", 64'(flush_done_o), 64'd0);
    cw_ready_i = 1'b1;
    @(posedge clk_i); #1; cw_ready_i = 1'b0;
    @(negedge clk_i) check("flush_done_pulse", 64'(flush_done_o), 64'd1);
    @(posedge clk_i); #1; flush_i = 1'b0; sym_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_done_single", 64'(flush_done_o), 64'd0);
    check("flush_clr_cnt", 64'(cb_ap_cnt_o), 64'd0);
    check("flush_after_valid", 64'(cw_valid_o), 64'd0);
    @(posedge clk_i); #1;

    // Asynchronous reset in the middle of EMIT
    cb_mode = 0;
    send_sym(4'hF);
    @(negedge clk_i); @(negedge clk_i);
    check("rstmid_pre_valid", 64'(cw_valid_o), 64'd1);
    rst_n_i = 1'b0; #1;
    check("rstmid_valid", 64'(cw_valid_o), 64'd0);
    check("rstmid_length", 64'(cw_length_o), 64'd0);
    check("rstmid_data", 64'(cw_data_o), 64'd0);
    check("rstmid_sym_ready", 64'(sym_ready_o), 64'd1);
    check("rstmid_ap_cnt", 64'(cb_ap_cnt_o), 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(negedge clk_i) check("rstmid_after_valid", 64'(cw_valid_o), 64'd0);
    @(negedge clk_i) check("rstmid_after_valid2", 64'(cw_valid_o), 64'd0);

    // Randomized run against the prefix model
    do_reset();
    cb_mode = 3;
    mq.delete(); expq.delete(); ovf_m = 1'b0; ovf_n = 0;
    prev_hold = 1'b0; flush_act = 1'b0; new_flush = 1'b0; saw_done = 1'b0; flush_age = 0;
    p_len = '0; p_data = '0; p_flush = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (flush_act && saw_done) begin
        flush_i = 1'b0; flush_act = 1'b0; saw_done = 1'b0;
      end else if (!flush_act && cyc < 3800 && $urandom_range(0, 59) == 0) begin
        flush_i = 1'b1; flush_act = 1'b1; new_flush = 1'b1; flush_age = 0;
      end
      if (cyc < 3800) begin
        sym_valid_i = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        sym_data_i = s;
        cw_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        sym_valid_i = 1'b0; cw_ready_i = 1'b1;
      end
      @(negedge clk_i);
      if (new_flush) begin
        new_flush = 1'b0;
        if (mq.size() != 0) begin
          e.len = 6'(mq.size()); e.data = '0; e.flush = 1'b1; e.ap = pack_q();
          expq.push_back(e);
          mq.delete();
        end
      end
      if (flush_i) check("rnd_ready_under_flush", 64'(sym_ready_o), 64'd0);
      if (sym_valid_i && sym_ready_o) model_accept(sym_data_i);
      if (prev_hold) begin
        check("rnd_hold_valid", 64'(cw_valid_o), 64'd1);
        check("rnd_hold_length", 64'(cw_length_o), 64'(p_len));
        check("rnd_hold_data", 64'(cw_data_o), 64'(p_data));
        check("rnd_hold_flush", 64'(cw_flush_o), 64'(p_flush));
      end
      if (cw_valid_o && cw_ready_i) begin
        if (expq.size() == 0) begin
          check("rnd_unexpected_cw", 64'(cw_valid_o), 64'd0);
        end else begin
          e = expq.pop_front();
          check("rnd_cw_length", 64'(cw_length_o), 64'(e.len));
          check("rnd_cw_data", 64'(cw_data_o), 64'(e.data));
          check("rnd_cw_flush", 64'(cw_flush_o), 64'(e.flush));
          if (e.flush) check("rnd_residue_ap", cb_ap_data_o, e.ap);
        end
      end
      prev_hold = cw_valid_o && !cw_ready_i;
      p_len = cw_length_o; p_data = cw_data_o; p_flush = cw_flush_o;
      if (flush_done_o) begin
        if (!flush_act) check("rnd_spurious_done", 64'(flush_done_o), 64'd0);
        else saw_done = 1'b1;
      end
      if (flush_act) begin
        flush_age++;
        if (flush_age > 300) begin
          check("rnd_flush_timeout", 64'(saw_done), 64'd1);
          flush_i = 1'b0; flush_act = 1'b0; saw_done = 1'b0;
        end
      end
      @(posedge clk_i); #1;
    end
    check("rnd_drain_empty", 64'(expq.size()), 64'd0);
    check("rnd_flush_closed", 64'(flush_act), 64'd0);
    check("rnd_ovf_err", 64'(ovf_err_o), 64'(ovf_m));
    check("rnd_prefix_cnt", 64'(cb_ap_cnt_o), 64'(mq.size()));
    check("rnd_prefix_data", cb_ap_data_o, pack_q());
`ifdef CBCTRL_ERR_CNT_EN
    check("rnd_ovf_counter", 64'(ovf_cnt_o), 64'((ovf_n > 65535) ? 65535 : ovf_n));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/codebook_seq_ctrl.md
# codebook_seq_ctrl

Sequencer for the low-entropy codebook lookup in the hybrid entropy coder. Accepts a stream of 4-bit input symbols and builds the active prefix (symbol count plus packed nibbles). Drives one combinational codebook lookup block with that prefix, then emits the matched codeword on a valid/ready output. Sits between the symbol mapper and the bit packer. It also handles end-of-image flush of a partial prefix and prefix overflow.

## Interface
- CODEBOOK_LENGTH_MAX, 64, width of packed active-prefix bus
- ENCODE_DATALENGTH, 21, codeword data width
- AP_CNT_MAX, 12, longest prefix length (symbols) present in any codebook
- clk_i  in  1  clock; all state on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- sym_valid_i  in  1  input symbol valid
- sym_ready_o  out  1  input symbol accepted when valid&ready
- sym_data_i  in  4  symbol; 4'hF is the terminal/escape symbol
- flush_i  in  1  end-of-image flush request, level, held until flush_done_o
- flush_done_o  out  1  one-cycle pulse, flush complete
- cb_ap_cnt_o  out  6  prefix length to codebook
- cb_ap_data_o  out  CODEBOOK_LENGTH_MAX  packed prefix to codebook; newest symbol in [3:0]
- cb_match_i  in  1  codebook match
- cb_length_i  in  6  codebook codeword length
- cb_data_i  in  ENCODE_DATALENGTH  codebook codeword bits
- cw_valid_o  out  1  codeword valid
- cw_ready_i  in  1  downstream accepts codeword
- cw_length_o  out  6  codeword length in bits, or residue symbol count when cw_flush_o
- cw_data_o  out  ENCODE_DATALENGTH  codeword bits, right-aligned; 0 when cw_flush_o
- cw_flush_o  out  1  current output is a flush residue; residue symbols read from cb_ap_data_o
- ovf_err_o  out  1  sticky: prefix reached AP_CNT_MAX without match

## Operation
- States: ACCUM, LOOKUP, EMIT, FLUSH.
- ACCUM:
  - sym_ready_o = ~flush_i.
  - On accept: ap_data <= {ap_data[CODEBOOK_LENGTH_MAX-5:0], sym_data_i}, ap_cnt <= ap_cnt+1, go to LOOKUP.
  - On flush_i with ap_cnt==0: pulse flush_done_o and stay in ACCUM.
  - On flush_i with ap_cnt!=0: go to FLUSH.
  - flush_i has priority over a simultaneous sym_valid_i; the symbol is not accepted.
- LOOKUP: sample the cb_* inputs, which are driven by the registered prefix.
  - Match: latch cb_length_i/cb_data_i into the output registers, go to EMIT.
  - No match and ap_cnt==AP_CNT_MAX: set ovf_err_o, clear prefix, go to ACCUM.
  - Otherwise: go to ACCUM.
- EMIT: cw_valid_o=1. When cw_ready_i: clear prefix (ap_cnt=0, ap_data=0), go to ACCUM.
- FLUSH: cw_valid_o=1, cw_flush_o=1, cw_length_o=ap_cnt, prefix held. When cw_ready_i: clear prefix, pulse flush_done_o, go to ACCUM.
- cb_ap_cnt_o/cb_ap_data_o are always the registered prefix. Unused upper bits are 0.
- ovf_err_o is cleared only by reset.
- Reset: state ACCUM, ap_cnt 0, ap_data 0. All outputs 0 except sym_ready_o, which is 1 when flush_i=0.
- A reset mid-EMIT or mid-FLUSH drops the pending codeword. No partial output follows reset.

## Timing
- Symbol accepted in cycle N. Codebook inputs valid in N+1 (LOOKUP). Codeword valid from N+2.
- Peak throughput: one symbol per 2 cycles without match; 3 cycles per matching symbol when cw_ready_i is held high.
- cw_* outputs are registered and held stable while cw_valid_o=1 and cw_ready_i=0.
- sym_ready_o is combinational from state and flush_i only. There is no combinational path from sym_valid_i or cw_ready_i to sym_ready_o.
- The codebook lookup block must settle within one cycle; the path is cb_ap_* register to cb_* sample register.

## Configuration
- CBCTRL_ERR_CNT_EN:
  - Defined: adds output ovf_cnt_o (16 bits). It increments on each overflow event and saturates at 16'hFFFF. Reset value 0.
  - Undefined: port absent; only sticky ovf_err_o.

## Structure
- Shared package cbctrl_pkg holds:
  - state enum cbctrl_state_t (ACCUM, LOOKUP, EMIT, FLUSH)
  - SYM_W=4 and SYM_ESC=4'hF
  - default AP_CNT_MAX=12
- One sub-module: codebook_ctrl_outbuf. It is the codeword/flush holding register with valid/ready hold logic; the FSM loads it in LOOKUP and FLUSH.
- The codebook lookup block is instantiated outside, in the parent. This keeps one controller reusable across all codebook variants.

## Test plan
- Single symbol F; codebook model returns match, length 10, data 10'h3E8. Expect cw_valid_o two cycles after accept, cw_length_o=10, cw_data_o=0x3E8, prefix cleared after handshake.
- Symbols 0,2,F; model matches only 3/'h02F with length 15, data 15'h7FF0. Expect no output after 0 or 2, one codeword after F, cb_ap_data_o='h02F during its LOOKUP.
- Hold cw_ready_i low 5 cycles during EMIT. Expect cw_* stable, sym_ready_o=0, and no symbol lost when ready returns.
- 12 symbols of 0 with no match. Expect ovf_err_o=1 after the 12th LOOKUP, prefix cleared. With CBCTRL_ERR_CNT_EN, ovf_cnt_o=1.
- Symbols 1,3, then flush_i asserted in the same cycle as sym_valid_i. Expect the symbol not accepted; FLUSH output with cw_flush_o=1, cw_length_o=2, cb_ap_data_o='h13; then flush_done_o pulse.
- Assert rst_n_i low mid-EMIT. Expect all outputs at reset values immediately (asynchronous), and cw_valid_o=0 after release.
